// File: rtl/boot_pkg.sv
// Shared types and constants for the byte-stream boot loader.
package boot_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN_LO,
    ST_LEN_HI,
    ST_DATA,
    ST_CSUM,
    ST_DONE
  } boot_state_e;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_LEN     = 2'd1;
  localparam logic [1:0] ERR_CSUM    = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

endpackage

// File: rtl/boot_word_packer.sv
// Assembles little-endian 32-bit words from a byte stream.
// word_o is the word including the byte presented this cycle, so the
// parent can register it in the same edge that word_done_o is seen.
module boot_word_packer (
  input  logic        clk,
  input  logic        resetn,
  input  logic        clear_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        word_done_o
);

  logic [1:0]  idx_q, idx_d;
  logic [31:0] word_q, word_d;

  // Insert the incoming byte at its lane and advance the byte index.
  always_comb begin
    idx_d  = idx_q;
    word_d = word_q;
    if (clear_i) begin
      idx_d  = '0;
      word_d = '0;
    end else if (byte_valid_i) begin
      case (idx_q)
        2'd0:    word_d[7:0]   = byte_i;
        2'd1:    word_d[15:8]  = byte_i;
        2'd2:    word_d[23:16] = byte_i;
        default: word_d[31:24] = byte_i;
      endcase
      idx_d = idx_q + 2'd1;
    end
  end

  // Byte index and partial-word storage.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      idx_q  <= '0;
      word_q <= '0;
    end else begin
      idx_q  <= idx_d;
      word_q <= word_d;
    end
  end

  assign word_o      = word_d;
  assign word_done_o = byte_valid_i && !clear_i && (idx_q == 2'd3);

endmodule

// File: rtl/boot_loader.sv
// Parses a framed program image from a UART byte stream, writes words to
// the boot RAM and releases the CPU reset once the checksum verifies.
// rx_valid is a one-cycle strobe with no backpressure: every strobe is
// consumed in the cycle it is seen.
module boot_loader
  import boot_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 8,
  parameter logic [7:0]  SYNC_BYTE      = DEFAULT_SYNC_BYTE,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  output logic                  ram_wen,
  output logic [ADDR_WIDTH-1:0] ram_waddr,
  output logic [31:0]           ram_wdata,
  output logic                  cpu_resetn,
  output logic                  done,
  output logic                  error,
  output logic [1:0]            err_code,
  output boot_state_e           dbg_state
);

  localparam int unsigned   GW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(TIMEOUT_CYCLES - 1);
  localparam logic [32:0]   MAX_N    = 33'd1 << ADDR_WIDTH;

  boot_state_e           state_q, state_d;
  logic [15:0]           len_q, len_d;
  logic [15:0]           widx_q, widx_d;
  logic [7:0]            sum_q, sum_d;
  logic [GW-1:0]         gap_q, gap_d;
  logic                  wen_q, wen_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic                  cpu_q, cpu_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic [1:0]            code_q, code_d;

  logic [15:0] n_w;
  logic        n_ok;
  logic        in_frame;
  logic        pk_clear, pk_valid, pk_done;
  logic [31:0] pk_word;

  assign n_w      = {rx_data, len_q[7:0]};
  assign n_ok     = (n_w != 16'd0) && ({17'd0, n_w} <= MAX_N);
  assign in_frame = (state_q == ST_LEN_LO) || (state_q == ST_LEN_HI) ||
                    (state_q == ST_DATA)   || (state_q == ST_CSUM);
  assign pk_clear = rx_valid && (state_q == ST_LEN_HI);
  assign pk_valid = rx_valid && (state_q == ST_DATA);

  boot_word_packer u_packer (
    .clk          (clk),
    .resetn       (resetn),
    .clear_i      (pk_clear),
    .byte_valid_i (pk_valid),
    .byte_i       (rx_data),
    .word_o       (pk_word),
    .word_done_o  (pk_done)
  );

  // Next-state, counters and registered output values.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    widx_d  = widx_q;
    sum_d   = sum_q;
    gap_d   = '0;
    wen_d   = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    cpu_d   = cpu_q;
    done_d  = done_q;
    err_d   = err_q;
    code_d  = code_q;
    if (in_frame && !rx_valid) begin
      // A byte in the final idle cycle takes the other branch, so it wins.
      if (gap_q == GAP_LAST) begin
        state_d = ST_IDLE;
        err_d   = 1'b1;
        code_d  = ERR_TIMEOUT;
      end else begin
        gap_d = gap_q + GW'(1);
      end
    end else if (rx_valid) begin
      case (state_q)
        ST_IDLE: begin
          if (rx_data == SYNC_BYTE) begin
            state_d = ST_LEN_LO;
            err_d   = 1'b0;
            code_d  = ERR_NONE;
          end
        end
        ST_LEN_LO: begin
          len_d[7:0] = rx_data;
          state_d    = ST_LEN_HI;
        end
        ST_LEN_HI: begin
          len_d[15:8] = rx_data;
          if (n_ok) begin
            state_d = ST_DATA;
            widx_d  = '0;
            sum_d   = '0;
          end else begin
            state_d = ST_IDLE;
            err_d   = 1'b1;
            code_d  = ERR_LEN;
          end
        end
        ST_DATA: begin
          sum_d = sum_q + rx_data;
          if (pk_done) begin
            wen_d   = 1'b1;
            waddr_d = widx_q[ADDR_WIDTH-1:0];
            wdata_d = pk_word;
            if (widx_q == len_q - 16'd1) state_d = ST_CSUM;
            else                         widx_d  = widx_q + 16'd1;
          end
        end
        ST_CSUM: begin
          if (rx_data == sum_q) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            cpu_d   = 1'b1;
          end else begin
            state_d = ST_IDLE;
            err_d   = 1'b1;
            code_d  = ERR_CSUM;
          end
        end
        default: ;  // ST_DONE absorbs everything until reset
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
      widx_q  <= '0;
      sum_q   <= '0;
      gap_q   <= '0;
      wen_q   <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      cpu_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= ERR_NONE;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      widx_q  <= widx_d;
      sum_q   <= sum_d;
      gap_q   <= gap_d;
      wen_q   <= wen_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      cpu_q   <= cpu_d;
      done_q  <= done_d;
      err_q   <= err_d;
      code_q  <= code_d;
    end
  end

  assign ram_wen    = wen_q;
  assign ram_waddr  = waddr_q;
  assign ram_wdata  = wdata_q;
  assign cpu_resetn = cpu_q;
  assign done       = done_q;
  assign error      = err_q;
  assign err_code   = code_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_boot_loader.sv
// Directed bench for boot_loader with a RAM-write scoreboard.
module tb_boot_loader;
  import boot_pkg::*;

  localparam int AW = 8;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          rx_valid = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          ram_wen;
  logic [AW-1:0] ram_waddr;
  logic [31:0]   ram_wdata;
  logic          cpu_resetn;
  logic          done;
  logic          error;
  logic [1:0]    err_code;
  boot_state_e   dbg_state;

  int errors = 0;
  int checks = 0;
  int wen_count = 0;
  int wen_mark;
  logic [39:0] exp_q[$];
  logic [7:0]  dq[$];

  boot_loader #(.ADDR_WIDTH(AW), .SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(TO)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .ram_wen    (ram_wen),
    .ram_waddr  (ram_waddr),
    .ram_wdata  (ram_wdata),
    .cpu_resetn (cpu_resetn),
    .done       (done),
    .error      (error),
    .err_code   (err_code),
    .dbg_state  (dbg_state)
  );

  // clock
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // scoreboard: every RAM write must match the head of exp_q
  always @(negedge clk) begin
    if (resetn && ram_wen === 1'b1) begin
      wen_count++;
      checks++;
      assert (exp_q.size() > 0) else begin
        errors++;
        $error("FAIL wr_unexpected observed=%0h_%0h expected=none", ram_waddr, ram_wdata);
      end
      if (exp_q.size() > 0) chk("wr", {ram_waddr, ram_wdata}, exp_q.pop_front());
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    idle(gap);
  endtask

  task automatic reset_and_check(input string tag);
    @(posedge clk);
    #1;
    resetn = 1'b0;
    #3;
    chk({tag, "_wen"},   40'(ram_wen),    40'(0));
    chk({tag, "_waddr"}, 40'(ram_waddr),  40'(0));
    chk({tag, "_wdata"}, 40'(ram_wdata),  40'(0));
    chk({tag, "_cpu"},   40'(cpu_resetn), 40'(0));
    chk({tag, "_done"},  40'(done),       40'(0));
    chk({tag, "_err"},   40'({error, err_code}), 40'(0));
    chk({tag, "_state"}, 40'(dbg_state),  40'(ST_IDLE));
    @(posedge clk);
    #1;
    resetn = 1'b1;
    idle(1);
  endtask

  function automatic logic [7:0] model_sum();
    logic [7:0] s = 8'h00;
    foreach (dq[i]) s = s + dq[i];
    return s;
  endfunction

  // sends SYNC, length, dq and csum; expected writes pushed as words complete
  task automatic send_image(input logic [15:0] n, input int gap, input logic [7:0] csum,
                            input bit expect_wr);
    logic [31:0] w;
    w = '0;
    send_byte(8'hA5, gap);
    chk("sync_clears_err", 40'({error, err_code}), 40'(0));
    send_byte(n[7:0], gap);
    send_byte(n[15:8], gap);
    foreach (dq[i]) begin
      case (i % 4)
        0: w[7:0]   = dq[i];
        1: w[15:8]  = dq[i];
        2: w[23:16] = dq[i];
        default: w[31:24] = dq[i];
      endcase
      if (expect_wr && (i % 4 == 3)) exp_q.push_back({8'(i / 4), w});
      send_byte(dq[i], gap);
    end
    if (expect_wr) chk("done_before_csum", 40'(done), 40'(0));
    send_byte(csum, 0);
  endtask

  initial begin
    // reset values
    idle(2);
    reset_and_check("rst");

    // junk before sync, then minimal image at one byte per cycle
    send_byte(8'h00, 0);
    send_byte(8'h13, 0);
    send_byte(8'hFF, 0);
    chk("junk_idle", 40'(dbg_state), 40'(ST_IDLE));
    wen_mark = wen_count;
    dq = '{8'h13, 8'h00, 8'h00, 8'h00};
    send_image(16'd1, 0, 8'h13, 1'b1);
    chk("min_done", 40'({done, cpu_resetn, error}), 40'(3'b110));
    chk("min_wcnt", 40'(wen_count - wen_mark), 40'(1));

    // after DONE, a further frame is ignored
    wen_mark = wen_count;
    dq = '{8'h01, 8'h02, 8'h03, 8'h04};
    send_image(16'd1, 0, 8'h0A, 1'b0);
    idle(2);
    chk("done_absorb_wcnt", 40'(wen_count - wen_mark), 40'(0));
    chk("done_absorb_st", 40'({dbg_state, done, cpu_resetn}), 40'({ST_DONE, 2'b11}));

    // three words, spaced bytes, checksum wraps past 0xFF
    reset_and_check("rst2");
    dq.delete();
    for (int i = 0; i < 12; i++) dq.push_back(8'hF0 + 8'(i));
    wen_mark = wen_count;
    send_image(16'd3, 4, model_sum(), 1'b1);
    chk("multi_done", 40'({done, cpu_resetn, error}), 40'(3'b110));
    chk("multi_wcnt", 40'(wen_count - wen_mark), 40'(3));

    // bad checksum, then a good frame recovers
    reset_and_check("rst3");
    dq = '{8'h13, 8'h00, 8'h00, 8'h00};
    wen_mark = wen_count;
    send_image(16'd1, 0, 8'h00, 1'b1);
    chk("csum_err", 40'({error, err_code}), 40'({1'b1, ERR_CSUM}));
    chk("csum_cpu", 40'({cpu_resetn, done}), 40'(0));
    chk("csum_st", 40'(dbg_state), 40'(ST_IDLE));
    chk("csum_wcnt", 40'(wen_count - wen_mark), 40'(1));
    dq = '{8'h44, 8'h55, 8'h66, 8'h77};
    send_image(16'd1, 1, model_sum(), 1'b1);
    chk("recover_done", 40'({done, cpu_resetn, error}), 40'(3'b110));

    // bad lengths: zero and 2^AW + 1
    reset_and_check("rst4");
    send_byte(8'hA5, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    chk("len0_err", 40'({error, err_code}), 40'({1'b1, ERR_LEN}));
    chk("len0_st", 40'(dbg_state), 40'(ST_IDLE));
    send_byte(8'hA5, 0);
    chk("len_sync_clr", 40'({error, err_code}), 40'(0));
    send_byte(8'h01, 0);
    send_byte(8'h01, 0);
    chk("len257_err", 40'({error, err_code}), 40'({1'b1, ERR_LEN}));

    // timeout after two data bytes
    reset_and_check("rst5");
    send_byte(8'hA5, 0);
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    idle(TO - 1);
    chk("to_not_yet", 40'({error, dbg_state}), 40'({1'b0, ST_DATA}));
    idle(1);
    chk("to_err", 40'({error, err_code}), 40'({1'b1, ERR_TIMEOUT}));
    chk("to_st", 40'(dbg_state), 40'(ST_IDLE));

    // byte landing in the last idle cycle beats the timeout
    reset_and_check("rst6");
    send_byte(8'hA5, 0);
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    idle(TO - 1);
    send_byte(8'h33, 0);
    chk("to_edge_noerr", 40'({error, err_code}), 40'(0));
    exp_q.push_back({8'h00, 32'h44332211});
    send_byte(8'h44, 0);
    send_byte(8'hAA, 0);
    chk("to_edge_done", 40'({done, cpu_resetn, error}), 40'(3'b110));

    // reset in the middle of DATA
    reset_and_check("rst7");
    send_byte(8'hA5, 0);
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    send_byte(8'h01, 0);
    send_byte(8'h02, 0);
    send_byte(8'h03, 0);
    exp_q.push_back({8'h00, 32'h04030201});
    send_byte(8'h04, 0);
    send_byte(8'h05, 0);
    chk("mid_st", 40'(dbg_state), 40'(ST_DATA));
    reset_and_check("midrst");
    dq = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    send_image(16'd1, 0, model_sum(), 1'b1);
    chk("mid_recover", 40'({done, cpu_resetn, error}), 40'(3'b110));

    idle(3);
    chk("exp_q_empty", 40'(exp_q.size()), 40'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/boot_loader.md
# boot_loader

Byte-stream boot loader that sits directly upstream of the bootloader RAM. It consumes bytes from the SoC UART receiver, parses a framed program image, and writes 32-bit words into the RAM write port. It holds the CPU in reset until a complete image with a valid checksum has been loaded.

## Interface
Parameters:
- ADDR_WIDTH, 8, RAM word-address width; capacity is 2^ADDR_WIDTH words.
- SYNC_BYTE, 8'hA5, frame start marker.
- TIMEOUT_CYCLES, 100000, maximum idle gap between bytes inside a frame.

Ports:
- clk  in  1  system clock.
- resetn  in  1  reset; one clock, asynchronous, active-low.
- rx_valid  in  1  single-cycle strobe; rx_data holds a received byte.
- rx_data  in  8  received byte.
- ram_wen  out  1  RAM write enable, one-cycle pulse.
- ram_waddr  out  ADDR_WIDTH  RAM word address.
- ram_wdata  out  32  RAM write data.
- cpu_resetn  out  1  CPU reset; low until the load succeeds.
- done  out  1  image loaded and verified; sticky.
- error  out  1  last frame failed; sticky until the next SYNC_BYTE.
- err_code  out  2  cause of failure: 0 none, 1 bad length, 2 checksum, 3 timeout.

## Operation
- Frame format: SYNC_BYTE, LEN_LO, LEN_HI, then N×4 data bytes (little-endian words; word k goes to address k), then CSUM.
- N = {LEN_HI, LEN_LO}. N is valid only when 1 ≤ N ≤ 2^ADDR_WIDTH.
- CSUM = 8-bit sum, modulo 256, of all data bytes only.
- States: IDLE, LEN_LO, LEN_HI, DATA, CSUM, DONE.
- IDLE: non-sync bytes are discarded. SYNC_BYTE → LEN_LO, and clears error and err_code.
- LEN_LO → LEN_HI on a byte.
- LEN_HI: on a byte, check N.
  - Invalid N → IDLE, error=1, err_code=1.
  - Valid N → DATA, with byte index and word index reset to 0.
- DATA:
  - Each byte is shifted into bits [8·i+7:8·i] of the word register, where i is the byte-in-word index (0..3). Each byte is added to the running sum.
  - On byte i=3, the completed word is written.
  - After word N−1 is written → CSUM.
- CSUM:
  - Match → DONE, done=1, cpu_resetn=1.
  - Mismatch → IDLE, error=1, err_code=2.
  - Words already written stay in RAM; the CPU stays in reset.
- DONE: absorbing. All further bytes are ignored, including SYNC_BYTE. Only resetn leaves DONE.
- Timeout:
  - The gap counter runs in LEN_LO, LEN_HI, DATA and CSUM, and clears on every rx_valid.
  - When TIMEOUT_CYCLES consecutive cycles pass with no rx_valid → IDLE, error=1, err_code=3.
  - If rx_valid arrives in the same cycle the timeout would fire, the byte is processed and no timeout occurs.
- A SYNC_BYTE value received inside LEN_LO..CSUM is treated as data, not as a resync.
- Reset mid-frame returns to IDLE with every output at its reset value. RAM contents are not cleared.

## Timing
- Reset values:
  - state=IDLE.
  - ram_wen=0, ram_waddr=0, ram_wdata=0.
  - cpu_resetn=0, done=0, error=0, err_code=0.
- All outputs are registered.
- ram_wen is high for exactly one cycle, the cycle after rx_valid of byte 3 of a word. ram_waddr and ram_wdata are valid in that same cycle.
- The fastest legal byte rate is one byte every cycle. Back-to-back words then produce ram_wen pulses 4 cycles apart.
- done and cpu_resetn rise together, one cycle after the CSUM byte's rx_valid.
- error and err_code update one cycle after the failing byte, or one cycle after the timeout condition.
- The gap counter is wide enough to hold TIMEOUT_CYCLES and never wraps.

## Structure
- Shared package boot_pkg holds:
  - state enumeration;
  - err_code constants ERR_NONE, ERR_LEN, ERR_CSUM, ERR_TIMEOUT;
  - default SYNC_BYTE.
- One sub-module: boot_word_packer.
  - Contains the byte-in-word index, 32-bit shift/assemble register and word-complete strobe.
  - Has a clear input driven on entry to DATA.
- The FSM, length/word counters, checksum accumulator and gap counter stay in boot_loader.

## Test plan
- Minimal image: frame A5 01 00 13 00 00 00 13 at one byte per cycle → exactly one ram_wen, waddr=0, wdata=32'h00000013; done=1 and cpu_resetn=1 the cycle after the last byte.
- Multi-word image: N=3 with data bytes chosen to wrap the checksum past 0xFF, bytes spaced 5 cycles apart → writes to addresses 0, 1, 2 with correct little-endian words; correct modulo-256 checksum accepted.
- Bad checksum: N=1 image with CSUM=8'h00 → one write still occurs, then error=1, err_code=2, cpu_resetn=0. A following correct frame → done=1 and error clears on its SYNC_BYTE.
- Bad length: A5 00 00 → error=1, err_code=1, back in IDLE. Also N=257 with ADDR_WIDTH=8 → err_code=1.
- Timeout: TIMEOUT_CYCLES=16, stop after byte 2 of a word → error=1, err_code=3 after 16 idle cycles. A byte arriving on cycle 16 exactly → no error.
- Robustness: junk bytes before sync are ignored; resetn asserted mid-DATA returns all outputs to reset values. After DONE, sending a new frame → no ram_wen pulses.
